// File: rtl/alu_req_arbiter_if.sv
// Request/ALU/response bundle for alu_req_arbiter.
// slave = arbiter side, master = requesters, ALU and response sink.
interface alu_req_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [3*NUM_REQ-1:0]      req_op;
    logic [DATA_W*NUM_REQ-1:0] req_num1;
    logic [DATA_W*NUM_REQ-1:0] req_num2;
    logic [DATA_W-1:0]         alu_num1;
    logic [DATA_W-1:0]         alu_num2;
    logic [2:0]                alu_sel;
    logic [DATA_W:0]           alu_result;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [ID_W-1:0]           resp_id;
    logic [DATA_W:0]           resp_data;
    logic                      busy;

    modport slave (
        input  req_valid, req_op, req_num1, req_num2, alu_result, resp_ready,
        output req_ready, alu_num1, alu_num2, alu_sel, resp_valid, resp_id, resp_data, busy
    );

    modport master (
        output req_valid, req_op, req_num1, req_num2, alu_result, resp_ready,
        input  req_ready, alu_num1, alu_num2, alu_sel, resp_valid, resp_id, resp_data, busy
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Define ALU_REQ_ARBITER_STATS_EN to add the 16-bit ops_done completion counter.
module alu_req_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_req_arbiter_if.slave    bus
`ifdef ALU_REQ_ARBITER_STATS_EN
    ,
    output logic [15:0]         ops_done
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant;
    logic [ID_W-1:0]     grant_next;
    logic                grant_found;
    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]  valid_rot;
    int unsigned         grant_sum;
    logic [2:0]          pick_op;
    logic [DATA_W-1:0]   pick_num1;
    logic [DATA_W-1:0]   pick_num2;

    // Rotate valids so bit 0 is rr_ptr; first set bit is the grant offset.
    always_comb begin
        valid_dbl   = {bus.req_valid, bus.req_valid} >> rr_ptr;
        valid_rot   = valid_dbl[NUM_REQ-1:0];
        grant_found = 1'b0;
        grant       = '0;
        grant_sum   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && valid_rot[k]) begin
                grant_found = 1'b1;
                grant_sum   = 32'(rr_ptr) + k;
                if (grant_sum >= NUM_REQ)
                    grant_sum = grant_sum - NUM_REQ;
                grant       = ID_W'(grant_sum);
            end
        end
        grant_next = (32'(grant) == NUM_REQ - 1) ? '0 : grant + ID_W'(1);
    end

    always_comb begin
        pick_op   = '0;
        pick_num1 = '0;
        pick_num2 = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                pick_op   = bus.req_op[3*i +: 3];
                pick_num1 = bus.req_num1[DATA_W*i +: DATA_W];
                pick_num2 = bus.req_num2[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (!rst && state == IDLE && grant_found)
            bus.req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            bus.alu_num1   <= '0;
            bus.alu_num2   <= '0;
            bus.alu_sel    <= '0;
            bus.resp_id    <= '0;
            bus.resp_data  <= '0;
            bus.resp_valid <= 1'b0;
            bus.busy       <= 1'b0;
`ifdef ALU_REQ_ARBITER_STATS_EN
            ops_done       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        bus.alu_sel  <= pick_op;
                        bus.alu_num1 <= pick_num1;
                        bus.alu_num2 <= pick_num2;
                        bus.resp_id  <= grant;
                        rr_ptr       <= grant_next;
                        bus.busy     <= 1'b1;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    bus.resp_data  <= bus.alu_result;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
`ifdef ALU_REQ_ARBITER_STATS_EN
                        ops_done       <= ops_done + 16'd1;
`endif
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: round-robin model plus response scoreboard.
module tb_alu_req_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned DW  = 16;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW:0]    data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_req_arbiter_if #(.NUM_REQ(NR), .ID_W(IDW), .DATA_W(DW)) bus ();

`ifdef ALU_REQ_ARBITER_STATS_EN
    logic [15:0] ops_done;
`endif

    alu_req_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef ALU_REQ_ARBITER_STATS_EN
        ,
        .ops_done (ops_done)
`endif
    );

    always #5 clk = ~clk;

    logic [2:0]    op_a [NR];
    logic [DW-1:0] n1_a [NR];
    logic [DW-1:0] n2_a [NR];

    exp_t          sb [$];
    int unsigned   vectors     = 0;
    int unsigned   miscompares = 0;
    int unsigned   m_rr        = 0;
    int unsigned   seq         = 0;
    logic [15:0]   m_ops       = '0;

    // Reference ALU: stands in for sixteen_bit_Alu.
    function automatic logic [DW:0] alu_fn(input logic [2:0] sel, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        case (sel)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a, 1'b0};
            default: return {1'b0, a >> 1};
        endcase
    endfunction

    always_comb bus.alu_result = alu_fn(bus.alu_sel, bus.alu_num1, bus.alu_num2);

    always_comb begin
        bus.req_op   = '0;
        bus.req_num1 = '0;
        bus.req_num2 = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_op[3*i +: 3]     = op_a[i];
            bus.req_num1[DW*i +: DW] = n1_a[i];
            bus.req_num2[DW*i +: DW] = n2_a[i];
        end
    end

    function automatic int unsigned model_pick(input logic [NR-1:0] v, input int unsigned rr);
        for (int unsigned k = 0; k < NR; k++) begin
            int unsigned idx;
            idx = (rr + k) % NR;
            if (((v >> idx) & NR'(1)) != '0)
                return idx;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_payloads();
        for (int i = 0; i < NR; i++) begin
            op_a[i] = 3'(seq + 32'(i));
            n1_a[i] = 16'($urandom);
            n2_a[i] = 16'($urandom);
        end
        seq++;
    endtask

    // Entered at posedge+1 in IDLE; returns at posedge+1 of the first IDLE cycle after handshake.
    task automatic run_op(input logic [NR-1:0] vmask, input int unsigned stall);
        int unsigned g;
        exp_t e;
        bus.req_valid  = vmask;
        bus.resp_ready = (stall == 0);
        g = model_pick(vmask, m_rr);
        e.id   = IDW'(g);
        e.data = alu_fn(op_a[g], n1_a[g], n2_a[g]);
        sb.push_back(e);
        m_rr = (g + 1) % NR;

        @(negedge clk);
        chk("grant_onehot", 32'(bus.req_ready), 32'(NR'(1) << g));
        chk("busy_idle", 32'(bus.busy), 0);
        @(posedge clk); #1;

        @(negedge clk);
        chk("exec_ready", 32'(bus.req_ready), 0);
        chk("exec_busy", 32'(bus.busy), 1);
        chk("exec_valid", 32'(bus.resp_valid), 0);
        chk("alu_sel", 32'(bus.alu_sel), 32'(op_a[g]));
        chk("alu_num1", 32'(bus.alu_num1), 32'(n1_a[g]));
        chk("alu_num2", 32'(bus.alu_num2), 32'(n2_a[g]));
        @(posedge clk); #1;

        for (int unsigned s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.resp_valid), 1);
            chk("stall_id", 32'(bus.resp_id), 32'(sb[0].id));
            chk("stall_data", 32'(bus.resp_data), 32'(sb[0].data));
            chk("stall_ready", 32'(bus.req_ready), 0);
            chk("stall_busy", 32'(bus.busy), 1);
            @(posedge clk); #1;
        end

        bus.resp_ready = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        chk("resp_valid", 32'(bus.resp_valid), 1);
        chk("resp_id", 32'(bus.resp_id), 32'(e.id));
        chk("resp_data", 32'(bus.resp_data), 32'(e.data));
        @(posedge clk); #1;
        m_ops = m_ops + 16'd1;
        bus.resp_ready = 1'b0;
        chk("resp_drop", 32'(bus.resp_valid), 0);
        chk("busy_done", 32'(bus.busy), 0);
    endtask

    task automatic idle_cycles(input int unsigned n);
        bus.req_valid = '0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(bus.req_ready), 0);
            chk("idle_busy", 32'(bus.busy), 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(bus.resp_valid), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_id"}, 32'(bus.resp_id), 0);
        chk({tag, "_data"}, 32'(bus.resp_data), 0);
        chk({tag, "_sel"}, 32'(bus.alu_sel), 0);
        chk({tag, "_num1"}, 32'(bus.alu_num1), 0);
        chk({tag, "_num2"}, 32'(bus.alu_num2), 0);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_values("rst");
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst   = 1'b0;
        m_rr  = 0;
        m_ops = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned g;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            op_a[i] = '0;
            n1_a[i] = '0;
            n2_a[i] = '0;
        end

        do_reset();

        // Single request, carry-out of the add.
        op_a[0] = 3'd0;
        n1_a[0] = 16'hFFFF;
        n2_a[0] = 16'h0001;
        run_op(4'b0001, 0);
        idle_cycles(2);

        // Continuous contention from a fresh pointer: 0,1,2,3,0.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            load_payloads();
            run_op(4'b1111, 0);
        end

        // Backpressure on requester 1 (rr now 2 after this op).
        load_payloads();
        run_op(4'b0010, 5);

        // Skip: pointer at 2 with 1010 -> grant 3, then pointer 0 -> grant 1.
        load_payloads();
        run_op(4'b1010, 0);
        load_payloads();
        run_op(4'b1010, 1);
        idle_cycles(3);

        // Requester just served is passed over while others are valid.
        load_payloads();
        run_op(4'b0101, 0);
        load_payloads();
        run_op(4'b0101, 0);

        // Reset while in RESP drops the operation.
        load_payloads();
        g = model_pick(4'b0100, m_rr);
        bus.req_valid  = 4'b0100;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("drop_grant", 32'(bus.req_ready), 32'(NR'(1) << g));
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop_resp_valid", 32'(bus.resp_valid), 1);
        rst           = 1'b1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_values("midrst");
        @(posedge clk); #1;
        rst   = 1'b0;
        m_rr  = 0;
        m_ops = '0;
        idle_cycles(2);
        chk("sb_empty", 32'(sb.size()), 0);

        for (int r = 0; r < 3; r++) begin
            load_payloads();
            run_op(4'b1111, 0);
        end
`ifdef ALU_REQ_ARBITER_STATS_EN
        chk("ops_done_3", 32'(ops_done), 32'(m_ops));
        force dut.ops_done = 16'hFFFF;
        #1;
        release dut.ops_done;
        m_ops = 16'hFFFF;
        load_payloads();
        run_op(4'b0010, 0);
        chk("ops_done_wrap", 32'(ops_done), 32'(m_ops));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
